mdio_master: RTL and testbench

- Clause-22 MDIO management master. Serialises PHY register read/write commands onto eth_mdc and eth_mdio_o/eth_mdio_t, and returns read data sampled from eth_mdio_i.
- Sits directly upstream of the top-level MDIO IOBUF. Its eth_mdio_o, eth_mdio_t and eth_mdio_i connect to that IOBUF's I, T and O pins; eth_mdc goes straight to the pin.
- Commands come from the SGMII driver's PHY bring-up logic (autoneg restart, PHY config).

---
 rtl/mdio_master.sv | 175 +++++++++++++++++
 tb/tb_mdio_master.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/mdio_master.sv
// mdio_master: Clause-22 MDIO master that serialises PHY register read/write frames.
//
// Ports:
//   clock, reset      system clock, asynchronous active-high reset
//   cmd_*             command request (valid/ready handshake); fields latched on acceptance
//   rsp_valid         one-cycle pulse at the end of every frame
//   rsp_rdata         read data (0 after a write); holds until the next acceptance
//   rsp_error         read only: PHY left the second turnaround bit high
//   busy              high from the cycle after acceptance through the rsp_valid cycle
//   eth_mdc           management clock, low outside frames
//   eth_mdio_o/_t/_i  IOBUF I / T (1 = released) / O
module mdio_master #(
   parameter int CLK_DIV       = 25,
   parameter int PREAMBLE_BITS = 32
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_write,
   input  logic [4:0]  cmd_phy_addr,
   input  logic [4:0]  cmd_reg_addr,
   input  logic [15:0] cmd_wdata,
   output logic        rsp_valid,
   output logic [15:0] rsp_rdata,
   output logic        rsp_error,
   output logic        busy,
   output logic        eth_mdc,
   output logic        eth_mdio_o,
   output logic        eth_mdio_t,
   input  logic        eth_mdio_i
);
   localparam int DIV_W = $clog2(CLK_DIV);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   if (CLK_DIV < 4) begin : g_bad_div
      $error("mdio_master: CLK_DIV must be >= 4");
   end
   if (PREAMBLE_BITS < 0 || PREAMBLE_BITS > 32) begin : g_bad_pre
      $error("mdio_master: PREAMBLE_BITS must be 0..32");
   end

   typedef enum logic [2:0] {IDLE, PREAMBLE, HEADER, TA, DATA, DONE} state_t;

   state_t            state_q, state_d;
   logic [5:0]        cnt_q, cnt_d;
   logic [DIV_W-1:0]  div_q, div_d;
   logic              ph_q, ph_d;
   logic [1:0]        sync_q, sync_d;
   logic              write_q, write_d;
   logic [4:0]        phy_q, phy_d;
   logic [4:0]        reg_q, reg_d;
   logic [15:0]       wdata_q, wdata_d;
   logic [15:0]       rdata_q, rdata_d;
   logic              err_q, err_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic              busy_q, busy_d;
   logic              mdc_q, mdc_d;
   logic              mdio_o_q, mdio_o_d;
   logic              mdio_t_q, mdio_t_d;
   logic              accept, end_bit, smp, in_frame;
   logic [13:0]       hdr;

   assign cmd_ready  = state_q == IDLE;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_rdata  = rdata_q;
   assign rsp_error  = err_q;
   assign busy       = busy_q;
   assign eth_mdc    = mdc_q;
   assign eth_mdio_o = mdio_o_q;
   assign eth_mdio_t = mdio_t_q;

   always_comb begin
      accept  = cmd_valid && state_q == IDLE;
      // a bit ends on the last clock of its MDC high phase
      end_bit = ph_q && div_q == DIV_LAST;
      smp     = sync_q[1];
      sync_d  = {sync_q[0], eth_mdio_i};
      write_d = accept ? cmd_write : write_q;
      phy_d   = accept ? cmd_phy_addr : phy_q;
      reg_d   = accept ? cmd_reg_addr : reg_q;
      wdata_d = accept ? cmd_wdata : wdata_q;
      div_d   = div_q == DIV_LAST ? '0 : div_q + 1'b1;
      ph_d    = div_q == DIV_LAST ? ~ph_q : ph_q;
      state_d = state_q;
      cnt_d   = end_bit ? cnt_q + 6'd1 : cnt_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      case (state_q)
         IDLE: begin
            div_d = '0;
            ph_d  = 1'b0;
            cnt_d = '0;
            if (accept) begin
               state_d = PREAMBLE_BITS == 0 ? HEADER : PREAMBLE;
               rdata_d = '0;
               err_d   = 1'b0;
            end
         end
         PREAMBLE: if (end_bit && cnt_q == 6'(PREAMBLE_BITS - 1)) begin
            state_d = HEADER;
            cnt_d   = '0;
         end
         HEADER: if (end_bit && cnt_q == 6'd13) begin
            state_d = TA;
            cnt_d   = '0;
         end
         TA: if (end_bit && cnt_q == 6'd1) begin
            // a responding PHY pulls the second turnaround bit low
            err_d   = !write_q && smp;
            state_d = DATA;
            cnt_d   = '0;
         end
         DATA: if (end_bit) begin
            rdata_d = write_q ? rdata_q : {rdata_q[14:0], smp};
            state_d = cnt_q == 6'd15 ? DONE : DATA;
         end
         default: begin
            state_d = IDLE;
            div_d   = '0;
            ph_d    = 1'b0;
            cnt_d   = '0;
         end
      endcase
      // outputs are derived from the next state so they change on the first cycle of each bit
      in_frame    = state_d inside {PREAMBLE, HEADER, TA, DATA};
      hdr         = {2'b01, write_d ? 2'b01 : 2'b10, phy_d, reg_d};
      mdc_d       = in_frame && ph_d;
      mdio_t_d    = !(state_d == PREAMBLE || state_d == HEADER || (write_d && (state_d == TA || state_d == DATA)));
      mdio_o_d    = mdio_t_d ? 1'b1 :
                    state_d == HEADER ? hdr[4'd13 - cnt_d[3:0]] :
                    state_d == TA     ? ~cnt_d[0] :
                    state_d == DATA   ? wdata_d[4'd15 - cnt_d[3:0]] : 1'b1;
      rsp_valid_d = state_d == DONE;
      busy_d      = state_d != IDLE;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         div_q       <= '0;
         ph_q        <= 1'b0;
         sync_q      <= 2'b11;
         write_q     <= 1'b0;
         phy_q       <= '0;
         reg_q       <= '0;
         wdata_q     <= '0;
         rdata_q     <= '0;
         err_q       <= 1'b0;
         rsp_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         mdc_q       <= 1'b0;
         mdio_o_q    <= 1'b1;
         mdio_t_q    <= 1'b1;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         div_q       <= div_d;
         ph_q        <= ph_d;
         sync_q      <= sync_d;
         write_q     <= write_d;
         phy_q       <= phy_d;
         reg_q       <= reg_d;
         wdata_q     <= wdata_d;
         rdata_q     <= rdata_d;
         err_q       <= err_d;
         rsp_valid_q <= rsp_valid_d;
         busy_q      <= busy_d;
         mdc_q       <= mdc_d;
         mdio_o_q    <= mdio_o_d;
         mdio_t_q    <= mdio_t_d;
      end
   end
endmodule

// File: tb/tb_mdio_master.sv
// tb_mdio_master: directed, table-driven bench for mdio_master with a simple PHY model.
module tb_mdio_master;
   localparam int LAT = 513;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic        cmd_write = 1'b0;
   logic [4:0]  cmd_phy_addr = '0;
   logic [4:0]  cmd_reg_addr = '0;
   logic [15:0] cmd_wdata = '0;
   logic        rsp_valid;
   logic [15:0] rsp_rdata;
   logic        rsp_error;
   logic        busy;
   logic        eth_mdc;
   logic        eth_mdio_o;
   logic        eth_mdio_t;
   logic        eth_mdio_i = 1'b1;

   logic        phy_en = 1'b0;
   logic        phy_ta = 1'b0;
   logic [15:0] phy_data = '0;
   int          edge_n = 0;
   logic        mdc_prev = 1'b0;

   int checks = 0;
   int failures = 0;

   mdio_master #(.CLK_DIV(4), .PREAMBLE_BITS(32)) dut (
      .clock(clock), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_phy_addr(cmd_phy_addr), .cmd_reg_addr(cmd_reg_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error), .busy(busy),
      .eth_mdc(eth_mdc), .eth_mdio_o(eth_mdio_o), .eth_mdio_t(eth_mdio_t), .eth_mdio_i(eth_mdio_i)
   );

   always #5 clock = ~clock;

   // PHY model: line pulled up; when enabled, drives TA bit 2 and read data from each MDC rise
   always @(negedge clock) begin
      if (!busy) begin
         edge_n     = 0;
         eth_mdio_i = 1'b1;
      end else if (eth_mdc && !mdc_prev) begin
         if (phy_en)
            eth_mdio_i = edge_n == 47 ? phy_ta : edge_n >= 48 ? phy_data[63 - edge_n] : 1'b1;
         edge_n++;
      end
      mdc_prev = eth_mdc;
   end

   typedef struct packed {
      logic        write;
      logic [4:0]  phy;
      logic [4:0]  regad;
      logic [15:0] wdata;
      logic        phy_en;
      logic        phy_ta;
      logic [15:0] phy_data;
      logic [63:0] exp_o;
      logic [63:0] exp_t;
      logic [15:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   task automatic issue(input vec_t v);
      phy_en   = v.phy_en;
      phy_ta   = v.phy_ta;
      phy_data = v.phy_data;
      @(negedge clock);
      cmd_valid    = 1'b1;
      cmd_write    = v.write;
      cmd_phy_addr = v.phy;
      cmd_reg_addr = v.regad;
      cmd_wdata    = v.wdata;
      @(posedge clock);
      @(negedge clock);
      cmd_valid = 1'b0;
   endtask

   // captures one frame; returns on rsp_valid or after a bounded number of cycles
   task automatic run_frame(input vec_t v, output logic [63:0] o_cap, output logic [63:0] t_cap,
                            output int lat, output logic mdc_bad, output logic busy_bad, output logic done_bad);
      issue(v);
      o_cap = '0; t_cap = '0; lat = -1; mdc_bad = 0; busy_bad = 0; done_bad = 0;
      for (int n = 1; n <= 600 && lat < 0; n++) begin
         if (n > 1) @(negedge clock);
         if (rsp_valid) begin
            lat = n;
            done_bad = eth_mdc !== 1'b0 || eth_mdio_t !== 1'b1 || eth_mdio_o !== 1'b1 || busy !== 1'b1;
         end else begin
            if (busy !== 1'b1) busy_bad = 1;
            if (n <= 512) begin
               if (eth_mdc !== ((n - 1) % 8 >= 4)) mdc_bad = 1;
               if ((n - 1) % 8 == 1) begin
                  o_cap[63 - (n - 1) / 8] = eth_mdio_o;
                  t_cap[63 - (n - 1) / 8] = eth_mdio_t;
               end
            end
         end
      end
   endtask

   task automatic check_frame(input string nm, input vec_t v);
      logic [63:0] o_cap, t_cap;
      int lat;
      logic mdc_bad, busy_bad, done_bad;
      run_frame(v, o_cap, t_cap, lat, mdc_bad, busy_bad, done_bad);
      chk({nm, "_mdio_o"}, o_cap, v.exp_o);
      chk({nm, "_mdio_t"}, t_cap, v.exp_t);
      chk({nm, "_latency"}, 64'(lat), 64'(LAT));
      chk({nm, "_mdc_bad"}, 64'(mdc_bad), 64'd0);
      chk({nm, "_busy_bad"}, 64'(busy_bad), 64'd0);
      chk({nm, "_done_bad"}, 64'(done_bad), 64'd0);
      chk({nm, "_rdata"}, 64'(rsp_rdata), 64'(v.exp_rdata));
      chk({nm, "_error"}, 64'(rsp_error), 64'(v.exp_err));
      @(negedge clock);
      chk({nm, "_pulse_end"}, 64'({rsp_valid, cmd_ready, busy}), 64'b010);
      chk({nm, "_rdata_hold"}, 64'(rsp_rdata), 64'(v.exp_rdata));
   endtask

   initial begin
      logic idle_bad, extra;
      int r1, acc2, r2, acc_busy;
      vecs[0] = '{1'b1, 5'd1, 5'd0, 16'h1140, 1'b0, 1'b0, 16'h0000,
                  {32'hFFFF_FFFF, 14'b01_01_00001_00000, 2'b10, 16'h1140}, 64'h0, 16'h0000, 1'b0};
      vecs[1] = '{1'b0, 5'd7, 5'd2, 16'h0000, 1'b1, 1'b0, 16'h0141,
                  {32'hFFFF_FFFF, 14'b01_10_00111_00010, 18'h3FFFF}, {46'h0, 18'h3FFFF}, 16'h0141, 1'b0};
      vecs[2] = '{1'b0, 5'd3, 5'd1, 16'h0000, 1'b0, 1'b0, 16'h0000,
                  {32'hFFFF_FFFF, 14'b01_10_00011_00001, 18'h3FFFF}, {46'h0, 18'h3FFFF}, 16'hFFFF, 1'b1};
      vecs[3] = '{1'b1, 5'd31, 5'd31, 16'hA5C3, 1'b0, 1'b0, 16'h0000,
                  {32'hFFFF_FFFF, 14'b01_01_11111_11111, 2'b10, 16'hA5C3}, 64'h0, 16'h0000, 1'b0};
      vecs[4] = '{1'b0, 5'd16, 5'd17, 16'h0000, 1'b1, 1'b0, 16'h8001,
                  {32'hFFFF_FFFF, 14'b01_10_10000_10001, 18'h3FFFF}, {46'h0, 18'h3FFFF}, 16'h8001, 1'b0};
      vecs[5] = '{1'b0, 5'd0, 5'd0, 16'h0000, 1'b1, 1'b1, 16'h1234,
                  {32'hFFFF_FFFF, 14'b01_10_00000_00000, 18'h3FFFF}, {46'h0, 18'h3FFFF}, 16'h1234, 1'b1};

      // reset values
      repeat (3) @(negedge clock);
      chk("reset_outputs", 64'({eth_mdc, eth_mdio_o, eth_mdio_t, rsp_valid, busy, cmd_ready}), 64'b011001);
      chk("reset_rsp", 64'({rsp_rdata, rsp_error}), 64'd0);
      reset = 1'b0;

      // idle: MDC static, line released
      idle_bad = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clock);
         if (eth_mdc !== 1'b0 || eth_mdio_t !== 1'b1 || eth_mdio_o !== 1'b1 || cmd_ready !== 1'b1 || busy !== 1'b0)
            idle_bad = 1;
      end
      chk("idle_static", 64'(idle_bad), 64'd0);

      for (int i = 0; i < 6; i++) check_frame($sformatf("vec%0d", i), vecs[i]);

      // back-to-back: held cmd_valid accepted one cycle after rsp_valid; pulses while busy ignored
      phy_en = 1'b0;
      @(negedge clock);
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_phy_addr = 5'd2; cmd_reg_addr = 5'd4; cmd_wdata = 16'h0001;
      @(posedge clock);
      r1 = -1; acc2 = -1;
      for (int n = 1; n <= 600 && acc2 < 0; n++) begin
         @(negedge clock);
         cmd_write = 1'b0; cmd_phy_addr = 5'd5; cmd_reg_addr = 5'd6;
         if (rsp_valid && r1 < 0) r1 = n;
         if (cmd_valid && cmd_ready) acc2 = n;
      end
      chk("b2b_first_rsp", 64'(r1), 64'(LAT));
      chk("b2b_second_accept", 64'(acc2), 64'(LAT + 1));
      @(posedge clock);
      @(negedge clock);
      cmd_valid = 1'b0;
      r2 = -1; acc_busy = 0;
      for (int n = 1; n <= 600 && r2 < 0; n++) begin
         if (n > 1) @(negedge clock);
         cmd_valid = n >= 100 && n < 110;
         if (rsp_valid) r2 = n;
         if (cmd_valid && cmd_ready) acc_busy++;
      end
      cmd_valid = 1'b0;
      chk("b2b_second_rsp", 64'(r2), 64'(LAT));
      chk("b2b_read_nophy", 64'({rsp_rdata, rsp_error}), {47'd0, 16'hFFFF, 1'b1});
      chk("busy_accepts", 64'(acc_busy), 64'd0);
      extra = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clock);
         if (busy !== 1'b0 || rsp_valid !== 1'b0 || eth_mdc !== 1'b0) extra = 1;
      end
      chk("no_extra_frame", 64'(extra), 64'd0);

      // asynchronous reset mid-frame, in the high phase of bit 40
      issue(vecs[0]);
      repeat (325) @(negedge clock);
      chk("pre_reset_line", 64'({eth_mdc, eth_mdio_t, busy}), 64'b101);
      #2 reset = 1'b1;
      #1;
      chk("async_reset", 64'({eth_mdc, eth_mdio_t, eth_mdio_o, busy, rsp_valid, cmd_ready}), 64'b011001);
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;
      extra = 0;
      for (int i = 0; i < 600; i++) begin
         @(negedge clock);
         if (rsp_valid !== 1'b0 || eth_mdc !== 1'b0 || busy !== 1'b0) extra = 1;
      end
      chk("post_reset_quiet", 64'(extra), 64'd0);
      check_frame("after_reset", vecs[0]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
